imem_loader: RTL and testbench

- Boot-time writer for the instruction memory that the pipeline's fetch stage only reads.
- Accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word to the instruction memory write port at consecutive word-aligned addresses.
- Holds the core in stall (CORE_RUN=0) until a complete, checksum-verified image is loaded.

---
 rtl/imem_loader.sv | 169 ++++++++++++++++
 tb/tb_imem_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time loader assembling a framed byte stream into instruction memory words
// Header CNT_HI/CNT_LO, 4*N payload bytes MSB first, then an XOR checksum over the payload.
module imem_loader #(
  parameter int unsigned          ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0,
  parameter int unsigned          MAX_WORDS = 256
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              in_valid_i,
  input  logic [7:0]        in_data_i,
  output logic              in_ready_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [31:0]       wdata_o,
  output logic              core_run_o,
  output logic              err_o,
  output logic [15:0]       words_loaded_o
);

  typedef enum logic [2:0] {
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERROR
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [23:0]       asm_q, asm_d;
  logic [7:0]        chk_q, chk_d;
  logic [15:0]       words_q, words_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              ready_q, ready_d;
  logic              run_q, run_d;
  logic              err_q, err_d;

  logic              accept;
  logic [15:0]       n_hdr;

  assign accept = in_valid_i && ready_q;
  assign n_hdr  = {cnt_q[15:8], in_data_i};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bidx_d  = bidx_q;
    asm_d   = asm_q;
    chk_d   = chk_q;
    words_d = words_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    run_d   = run_q;
    err_d   = err_q;

    case (state_q)
      S_HDR_HI: begin
        if (accept) begin
          cnt_d   = {in_data_i, 8'h00};
          state_d = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (accept) begin
          cnt_d  = n_hdr;
          bidx_d = 2'd0;
          if (n_hdr == 16'd0) begin
            state_d = S_CHK;
          end else if ({16'd0, n_hdr} > MAX_WORDS) begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          asm_d  = {asm_q[15:0], in_data_i};
          chk_d  = chk_q ^ in_data_i;
          bidx_d = bidx_q + 2'd1;
          // Fourth byte completes a word: the write address is indexed by words already written.
          if (bidx_q == 2'd3) begin
            we_d    = 1'b1;
            wdata_d = {asm_q, in_data_i};
            waddr_d = BASE_ADDR + (ADDR_W'(words_q) << 2);
            words_d = words_q + 16'd1;
            if (words_d == cnt_q) begin
              state_d = S_CHK;
            end
          end
        end
      end
      S_CHK: begin
        if (accept) begin
          if (in_data_i == chk_q) begin
            state_d = S_DONE;
            run_d   = 1'b1;
          end else begin
            state_d = S_ERROR;
            err_d   = 1'b1;
          end
        end
      end
      S_DONE, S_ERROR: begin
        if (start_i) begin
          state_d = S_HDR_HI;
          cnt_d   = '0;
          bidx_d  = '0;
          chk_d   = '0;
          words_d = '0;
          waddr_d = BASE_ADDR;
          run_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_HDR_HI;
    endcase

    ready_d = (state_d == S_HDR_HI) || (state_d == S_HDR_LO) ||
              (state_d == S_DATA)   || (state_d == S_CHK);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_HDR_HI;
      cnt_q   <= '0;
      bidx_q  <= '0;
      asm_q   <= '0;
      chk_q   <= '0;
      words_q <= '0;
      waddr_q <= BASE_ADDR;
      wdata_q <= '0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      asm_q   <= asm_d;
      chk_q   <= chk_d;
      words_q <= words_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      ready_q <= ready_d;
      run_q   <= run_d;
      err_q   <= err_d;
    end
  end

  assign in_ready_o     = ready_q;
  assign we_o           = we_q;
  assign waddr_o        = waddr_q;
  assign wdata_o        = wdata_q;
  assign core_run_o     = run_q;
  assign err_o          = err_q;
  assign words_loaded_o = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed table-driven bench for imem_loader
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        core_run;
  logic        err;
  logic [15:0] words_loaded;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] wq[$];

  imem_loader #(
    .ADDR_W(32),
    .BASE_ADDR(32'h0000_0000),
    .MAX_WORDS(256)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .start_i(start),
    .in_valid_i(in_valid),
    .in_data_i(in_data),
    .in_ready_o(in_ready),
    .we_o(we),
    .waddr_o(waddr),
    .wdata_o(wdata),
    .core_run_o(core_run),
    .err_o(err),
    .words_loaded_o(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we) wq.push_back({waddr, wdata});
  end

  typedef struct packed {
    logic [3:0]  len;
    logic [95:0] bytes;
    logic        gap;
    logic [1:0]  nwe;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        run;
    logic        err;
    logic [15:0] wl;
  } vec_t;

  localparam int NV = 6;
  vec_t vec [NV];
  vec_t cur;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic gap);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for byte %0h", b);
    end
    @(negedge clk);
    if (gap) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_idle_after_start(input string tag);
    check({tag, "_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_run"},   64'(core_run), 64'd0);
    check({tag, "_err"},   64'(err), 64'd0);
    check({tag, "_wl"},    64'(words_loaded), 64'd0);
    check({tag, "_waddr"}, 64'(waddr), 64'd0);
  endtask

  int base;
  logic [63:0] got;
  logic [7:0]  b;

  initial begin
    vec[0] = '{len: 4'd11, bytes: 96'h0002_2008_0005_0109_5020_5500, gap: 1'b0, nwe: 2'd2,
               w0: 32'h2008_0005, w1: 32'h0109_5020, run: 1'b1, err: 1'b0, wl: 16'd2};
    vec[1] = '{len: 4'd3,  bytes: 96'h0000_0000_0000_0000_0000_0000, gap: 1'b0, nwe: 2'd0,
               w0: 32'h0, w1: 32'h0, run: 1'b1, err: 1'b0, wl: 16'd0};
    vec[2] = '{len: 4'd11, bytes: 96'h0002_2008_0005_0109_5020_5400, gap: 1'b0, nwe: 2'd2,
               w0: 32'h2008_0005, w1: 32'h0109_5020, run: 1'b0, err: 1'b1, wl: 16'd2};
    vec[3] = '{len: 4'd7,  bytes: 96'h0001_DEAD_BEEF_2200_0000_0000, gap: 1'b0, nwe: 2'd1,
               w0: 32'hDEAD_BEEF, w1: 32'h0, run: 1'b1, err: 1'b0, wl: 16'd1};
    vec[4] = '{len: 4'd2,  bytes: 96'h0101_0000_0000_0000_0000_0000, gap: 1'b0, nwe: 2'd0,
               w0: 32'h0, w1: 32'h0, run: 1'b0, err: 1'b1, wl: 16'd0};
    vec[5] = '{len: 4'd11, bytes: 96'h0002_2008_0005_0109_5020_5500, gap: 1'b1, nwe: 2'd2,
               w0: 32'h2008_0005, w1: 32'h0109_5020, run: 1'b1, err: 1'b0, wl: 16'd2};

    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_we",    64'(we), 64'd0);
    check("rst_waddr", 64'(waddr), 64'd0);
    check("rst_wdata", 64'(wdata), 64'd0);
    check("rst_run",   64'(core_run), 64'd0);
    check("rst_err",   64'(err), 64'd0);
    check("rst_wl",    64'(words_loaded), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", 64'(in_ready), 64'd1);

    // START while idle in HDR_HI must not disturb anything
    pulse_start();
    check_idle_after_start("start_in_hdr");

    for (int v = 0; v < NV; v++) begin
      cur  = vec[v];
      base = wq.size();
      for (int i = 0; i < int'(cur.len); i++) begin
        b = cur.bytes[95 - 8*i -: 8];
        send(b, cur.gap);
      end
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check($sformatf("v%0d_nwe", v), 64'(wq.size() - base), 64'(cur.nwe));
      if (cur.nwe >= 2'd1) begin
        got = (wq.size() > base) ? wq[base] : '1;
        check($sformatf("v%0d_write0", v), got, {32'h0000_0000, cur.w0});
      end
      if (cur.nwe >= 2'd2) begin
        got = (wq.size() > base + 1) ? wq[base + 1] : '1;
        check($sformatf("v%0d_write1", v), got, {32'h0000_0004, cur.w1});
      end
      check($sformatf("v%0d_run", v),   64'(core_run), 64'(cur.run));
      check($sformatf("v%0d_err", v),   64'(err), 64'(cur.err));
      check($sformatf("v%0d_wl", v),    64'(words_loaded), 64'(cur.wl));
      check($sformatf("v%0d_ready", v), 64'(in_ready), 64'd0);

      // Bytes offered in DONE/ERROR are not consumed and cause no writes
      base = wq.size();
      in_valid = 1'b1;
      in_data  = 8'hA5;
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("v%0d_hold_nwe", v), 64'(wq.size() - base), 64'd0);
      check($sformatf("v%0d_hold_ready", v), 64'(in_ready), 64'd0);

      pulse_start();
      check_idle_after_start($sformatf("v%0d_restart", v));
    end

    // START mid-payload is ignored
    base = wq.size();
    send(8'h00, 1'b0);
    send(8'h01, 1'b0);
    send(8'hDE, 1'b0);
    send(8'hAD, 1'b0);
    in_valid = 1'b0;
    pulse_start();
    check("start_in_data_ready", 64'(in_ready), 64'd1);
    send(8'hBE, 1'b0);
    send(8'hEF, 1'b0);
    send(8'h22, 1'b0);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    got = (wq.size() > base) ? wq[base] : '1;
    check("start_in_data_write", got, {32'h0000_0000, 32'hDEAD_BEEF});
    check("start_in_data_run", 64'(core_run), 64'd1);
    pulse_start();

    // Reset after 5 payload bytes aborts immediately, then a fresh load starts at 0
    send(8'h00, 1'b0);
    send(8'h02, 1'b0);
    send(8'h20, 1'b0);
    send(8'h08, 1'b0);
    send(8'h00, 1'b0);
    send(8'h05, 1'b0);
    send(8'h01, 1'b0);
    in_valid = 1'b0;
    check("midload_wl_before", 64'(words_loaded), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midload_rst_ready", 64'(in_ready), 64'd0);
    check("midload_rst_we",    64'(we), 64'd0);
    check("midload_rst_waddr", 64'(waddr), 64'd0);
    check("midload_rst_wdata", 64'(wdata), 64'd0);
    check("midload_rst_run",   64'(core_run), 64'd0);
    check("midload_rst_err",   64'(err), 64'd0);
    check("midload_rst_wl",    64'(words_loaded), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    base = wq.size();
    cur  = vec[0];
    for (int i = 0; i < int'(cur.len); i++) begin
      b = cur.bytes[95 - 8*i -: 8];
      send(b, 1'b0);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reload_nwe", 64'(wq.size() - base), 64'd2);
    got = (wq.size() > base) ? wq[base] : '1;
    check("reload_write0", got, {32'h0000_0000, 32'h2008_0005});
    got = (wq.size() > base + 1) ? wq[base + 1] : '1;
    check("reload_write1", got, {32'h0000_0004, 32'h0109_5020});
    check("reload_run", 64'(core_run), 64'd1);
    check("reload_err", 64'(err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
